// File: rtl/dm_target_selector_pkg.sv
// Shared types and constants for the mobile-side handover decision stage.
//   bs_id_t    : base-station index / target code (Bs1=0, Bs2=1, Bs3=2, BsNone=3)
//   dm_state_t : decision FSM states
//   SqThresh   : quality threshold also used by the base-station FSMs
//   lowest_req : picks the lowest-indexed asserted request bit
package dm_target_selector_pkg;

  typedef enum logic [1:0] {
    Bs1    = 2'd0,
    Bs2    = 2'd1,
    Bs3    = 2'd2,
    BsNone = 2'd3
  } bs_id_t;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StReport,
    StHold
  } dm_state_t;

  localparam int unsigned SqThresh = 50;
  localparam int unsigned NumBs    = 3;

  function automatic bs_id_t lowest_req(input logic [2:0] req);
    bs_id_t id;
    id = BsNone;
    if (req[0]) begin
      id = Bs1;
    end else if (req[1]) begin
      id = Bs2;
    end else if (req[2]) begin
      id = Bs3;
    end
    return id;
  endfunction

endpackage

// File: rtl/dm_target_selector_if.sv
// Bus between the radio front end / base stations and the DM target selector.
//   master : drives RSSI samples and base-station DM requests, observes DM outputs
//   slave  : the selector; receives samples/requests, drives per-BS quality/target,
//            busy flag and handover count
interface dm_target_selector_if #(
  parameter int unsigned SqW = 7
);

  logic           rssi_valid;
  logic [SqW-1:0] rssi_bs1;
  logic [SqW-1:0] rssi_bs2;
  logic [SqW-1:0] rssi_bs3;
  logic [2:0]     bs_request;    // {BS3, BS2, BS1} DM requests

  logic [SqW-1:0] DM_BS1_sq;
  logic [SqW-1:0] DM_BS2_sq;
  logic [SqW-1:0] DM_BS3_sq;
  logic [1:0]     DM_BS1_target;
  logic [1:0]     DM_BS2_target;
  logic [1:0]     DM_BS3_target;
  logic           dm_busy;
  logic [7:0]     ho_count;

  modport master (
    output rssi_valid, rssi_bs1, rssi_bs2, rssi_bs3, bs_request,
    input  DM_BS1_sq, DM_BS2_sq, DM_BS3_sq,
    input  DM_BS1_target, DM_BS2_target, DM_BS3_target,
    input  dm_busy, ho_count
  );

  modport slave (
    input  rssi_valid, rssi_bs1, rssi_bs2, rssi_bs3, bs_request,
    output DM_BS1_sq, DM_BS2_sq, DM_BS3_sq,
    output DM_BS1_target, DM_BS2_target, DM_BS3_target,
    output dm_busy, ho_count
  );

endinterface

// File: rtl/dm_target_selector_sq_averager.sv
// Block averager for one base station's RSSI stream.
//   clk, reset : clock, synchronous active-high reset
//   rssi_valid : sample present this cycle
//   sample     : raw RSSI sample
//   sq         : averaged quality (all ones until the first block completes)
//   avg_upd    : one-cycle pulse in the cycle sq takes a new value
// Every instance sees the same rssi_valid, so their sample counters stay in lockstep.
module dm_target_selector_sq_averager #(
  parameter int unsigned SqW     = 7,
  parameter int unsigned AvgLog2 = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rssi_valid,
  input  logic [SqW-1:0] sample,
  output logic [SqW-1:0] sq,
  output logic           avg_upd
);

  localparam int unsigned AccW = SqW + AvgLog2;

  logic [AccW-1:0]    acc_q, acc_d, sum;
  logic [AvgLog2-1:0] cnt_q, cnt_d;
  logic [SqW-1:0]     sq_q, sq_d;
  logic               upd_q, upd_d;

  assign sum = acc_q + AccW'(sample);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sq_d  = sq_q;
    upd_d = 1'b0;
    if (rssi_valid) begin
      cnt_d = cnt_q + AvgLog2'(1);
      if (&cnt_q) begin
        // Last sample of the block: fold it in directly and restart.
        sq_d  = SqW'(sum >> AvgLog2);
        acc_d = '0;
        upd_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      sq_q  <= '1;
      upd_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
      upd_q <= upd_d;
    end
  end

  assign sq      = sq_q;
  assign avg_upd = upd_q;

endmodule

// File: rtl/dm_target_selector.sv
// Mobile-side measurement and handover-decision stage.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of dm_target_selector_if (RSSI in, requests in, per-BS quality and
//                target codes out, dm_busy, saturating handover count)
// A serving BS raises its request; once averaged quality exists the FSM latches the lowest
// requester, picks the best BS with hysteresis and drives the chosen code on that BS's target
// until the request drops (or times out), then holds it a few cycles before resting again.
module dm_target_selector
  import dm_target_selector_pkg::*;
#(
  parameter int unsigned SqW        = 7,
  parameter int unsigned AvgLog2    = 2,
  parameter int unsigned Hyst       = 5,
  parameter int unsigned ReqTimeout = 16,
  parameter int unsigned HoldCyc    = 2
) (
  input logic                  clk,
  input logic                  reset,
  dm_target_selector_if.slave  bus
);

  localparam int unsigned TmoW  = (ReqTimeout > 1) ? $clog2(ReqTimeout) : 1;
  localparam int unsigned HoldW = (HoldCyc > 1) ? $clog2(HoldCyc) : 1;

  logic [SqW-1:0] sq  [NumBs];
  logic [SqW-1:0] smp [NumBs];
  logic [NumBs-1:0] upd;
  logic any_upd;

  assign smp[0] = bus.rssi_bs1;
  assign smp[1] = bus.rssi_bs2;
  assign smp[2] = bus.rssi_bs3;

  for (genvar k = 0; k < NumBs; k++) begin : g_avg
    dm_target_selector_sq_averager #(
      .SqW     (SqW),
      .AvgLog2 (AvgLog2)
    ) u_avg (
      .clk        (clk),
      .reset      (reset),
      .rssi_valid (bus.rssi_valid),
      .sample     (smp[k]),
      .sq         (sq[k]),
      .avg_upd    (upd[k])
    );
  end

  assign any_upd = |upd;

  dm_state_t         state_q, state_d;
  bs_id_t            req_id_q, req_id_d;
  bs_id_t            tgt_q, tgt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [7:0]        ho_q, ho_d;
  logic              avg_ready_q, avg_ready_d;
  logic              avg_ready;

  // Quality becomes usable in the same cycle the first average appears.
  assign avg_ready = avg_ready_q | any_upd;

  // Requester's quality and request line.
  logic [SqW-1:0] sq_req;
  logic           req_live;

  always_comb begin
    sq_req   = sq[0];
    req_live = bus.bs_request[0];
    unique case (req_id_q)
      Bs2: begin
        sq_req   = sq[1];
        req_live = bus.bs_request[1];
      end
      Bs3: begin
        sq_req   = sq[2];
        req_live = bus.bs_request[2];
      end
      default: begin
        sq_req   = sq[0];
        req_live = bus.bs_request[0];
      end
    endcase
  end

  // Argmax over registered quality; strict '>' keeps ties on the lower index.
  bs_id_t         best;
  logic [SqW-1:0] best_sq;
  logic [SqW:0]   req_plus_hyst;
  bs_id_t         eval_tgt;

  always_comb begin
    best    = Bs1;
    best_sq = sq[0];
    if (sq[1] > best_sq) begin
      best    = Bs2;
      best_sq = sq[1];
    end
    if (sq[2] > best_sq) begin
      best    = Bs3;
      best_sq = sq[2];
    end
    // One extra bit so requester quality plus margin cannot wrap.
    req_plus_hyst = {1'b0, sq_req} + (SqW + 1)'(Hyst);
    if ((best != req_id_q) && ({1'b0, best_sq} >= req_plus_hyst)) begin
      eval_tgt = best;
    end else begin
      eval_tgt = req_id_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_id_d    = req_id_q;
    tgt_d       = tgt_q;
    tmo_d       = tmo_q;
    hold_d      = hold_q;
    ho_d        = ho_q;
    avg_ready_d = avg_ready_q | any_upd;
    unique case (state_q)
      StIdle: begin
        if ((|bus.bs_request) && avg_ready) begin
          req_id_d = lowest_req(bus.bs_request);
          state_d  = StEval;
        end
      end
      StEval: begin
        tgt_d   = eval_tgt;
        tmo_d   = '0;
        state_d = StReport;
      end
      StReport: begin
        tmo_d = tmo_q + TmoW'(1);
        if (tgt_q == req_id_q) begin
          // Staying put: re-decide on fresh quality, stop when the BS lets go.
          if (!req_live) begin
            state_d = StIdle;
          end else if (any_upd) begin
            state_d = StEval;
          end
        end else if (!req_live || (tmo_q == TmoW'(ReqTimeout - 1))) begin
          state_d = StHold;
          hold_d  = '0;
          if (ho_q != 8'hFF) begin
            ho_d = ho_q + 8'd1;
          end
        end
      end
      StHold: begin
        hold_d = hold_q + HoldW'(1);
        if (hold_q == HoldW'(HoldCyc - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      req_id_q    <= Bs1;
      tgt_q       <= Bs1;
      tmo_q       <= '0;
      hold_q      <= '0;
      ho_q        <= '0;
      avg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_id_q    <= req_id_d;
      tgt_q       <= tgt_d;
      tmo_q       <= tmo_d;
      hold_q      <= hold_d;
      ho_q        <= ho_d;
      avg_ready_q <= avg_ready_d;
    end
  end

  // Each target rests at its own index; only the latched requester sees tgt.
  bs_id_t t1, t2, t3;

  always_comb begin
    t1 = Bs1;
    t2 = Bs2;
    t3 = Bs3;
    if ((state_q == StReport) || (state_q == StHold)) begin
      unique case (req_id_q)
        Bs2:     t2 = tgt_q;
        Bs3:     t3 = tgt_q;
        default: t1 = tgt_q;
      endcase
    end
  end

  assign bus.DM_BS1_sq     = sq[0];
  assign bus.DM_BS2_sq     = sq[1];
  assign bus.DM_BS3_sq     = sq[2];
  assign bus.DM_BS1_target = t1;
  assign bus.DM_BS2_target = t2;
  assign bus.DM_BS3_target = t3;
  assign bus.dm_busy       = (state_q != StIdle);
  assign bus.ho_count      = ho_q;

endmodule

// File: tb/tb_dm_target_selector.sv
module tb_dm_target_selector;
  import dm_target_selector_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dm_target_selector_if #(.SqW(7)) bus ();

  dm_target_selector #(
    .SqW        (7),
    .AvgLog2    (2),
    .Hyst       (5),
    .ReqTimeout (16),
    .HoldCyc    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         bs;
    logic [1:0] tgt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_sq[3];
  int   model_ho;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] tgt_of(input int k);
    case (k)
      0:       return bus.DM_BS1_target;
      1:       return bus.DM_BS2_target;
      default: return bus.DM_BS3_target;
    endcase
  endfunction

  function automatic logic [6:0] sq_of(input int k);
    case (k)
      0:       return bus.DM_BS1_sq;
      1:       return bus.DM_BS2_sq;
      default: return bus.DM_BS3_sq;
    endcase
  endfunction

  // Reference decision: argmax with lowest index on ties, margin of 5 to move.
  function automatic int model_target(input int req);
    int best;
    best = 0;
    for (int k = 1; k < 3; k++) begin
      if (model_sq[k] > model_sq[best]) best = k;
    end
    if ((best != req) && (model_sq[best] >= model_sq[req] + 5)) return best;
    return req;
  endfunction

  // Four samples per BS: base, base+1, base+2, base+3.
  task automatic send_block(input int b1, input int b2, input int b3);
    int s1, s2, s3;
    s1 = 0; s2 = 0; s3 = 0;
    for (int i = 0; i < 4; i++) begin
      bus.rssi_valid = 1'b1;
      bus.rssi_bs1   = 7'(b1 + i);
      bus.rssi_bs2   = 7'(b2 + i);
      bus.rssi_bs3   = 7'(b3 + i);
      s1 += b1 + i;
      s2 += b2 + i;
      s3 += b3 + i;
      tick();
    end
    bus.rssi_valid = 1'b0;
    model_sq[0] = s1 / 4;
    model_sq[1] = s2 / 4;
    model_sq[2] = s3 / 4;
  endtask

  // Raise a request, wait (bounded) for the FSM to take it, check the target 2 cycles on.
  task automatic serve(input int bs);
    exp_t e;
    bit   seen;
    e.bs  = bs;
    e.tgt = 2'(model_target(bs));
    sb_q.push_back(e);
    bus.bs_request[bs] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.dm_busy === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL serve_start bs%0d: dm_busy=%b want 1 within 40 cycles", bs, bus.dm_busy);
    end
    tick();
    e = sb_q.pop_front();
    total++;
    if (tgt_of(e.bs) !== e.tgt) begin
      bad++;
      $display("FAIL serve_target bs%0d: got %0d want %0d", e.bs, tgt_of(e.bs), e.tgt);
    end
  endtask

  // Drop the request (leaving 'keep' asserted) and check the hold window and count.
  task automatic finish_ho(input int bs, input logic [1:0] tgt, input logic [2:0] keep);
    bus.bs_request = keep;
    if (tgt != 2'(bs)) model_ho++;
    for (int h = 0; h < 2; h++) begin
      tick();
      total++;
      if (tgt_of(bs) !== tgt) begin
        bad++;
        $display("FAIL hold%0d bs%0d: got %0d want %0d", h, bs, tgt_of(bs), tgt);
      end
    end
    tick();
    total++;
    if (tgt_of(bs) !== 2'(bs) || bus.dm_busy !== 1'b0) begin
      bad++;
      $display("FAIL restore bs%0d: target=%0d busy=%b want target=%0d busy=0",
               bs, tgt_of(bs), bus.dm_busy, bs);
    end
    total++;
    if (bus.ho_count !== 8'(model_ho)) begin
      bad++;
      $display("FAIL ho_count bs%0d: got %0d want %0d", bs, bus.ho_count, model_ho);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (sq_of(k) !== 7'd127) begin
        bad++;
        $display("FAIL %s_sq%0d: got %0d want 127", tag, k + 1, sq_of(k));
      end
      total++;
      if (tgt_of(k) !== 2'(k)) begin
        bad++;
        $display("FAIL %s_target%0d: got %0d want %0d", tag, k + 1, tgt_of(k), k);
      end
    end
    total++;
    if (bus.dm_busy !== 1'b0 || bus.ho_count !== 8'd0) begin
      bad++;
      $display("FAIL %s_flags: busy=%b ho=%0d want busy=0 ho=0", tag, bus.dm_busy, bus.ho_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");
    total++;
    if (int'(bus.DM_BS1_sq) < SqThresh) begin
      bad++;
      $display("FAIL reset_thresh: sq1=%0d want >= %0d", bus.DM_BS1_sq, SqThresh);
    end
    for (int k = 0; k < 3; k++) model_sq[k] = 127;
    model_ho = 0;
  endtask

  task automatic test_averaging();
    bus.bs_request = 3'b001;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (bus.dm_busy !== 1'b0 || bus.DM_BS1_target !== 2'd0) begin
      bad++;
      $display("FAIL early_request: busy=%b target=%0d want busy=0 target=0",
               bus.dm_busy, bus.DM_BS1_target);
    end
    send_block(40, 59, 29);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (sq_of(k) !== 7'(model_sq[k])) begin
        bad++;
        $display("FAIL avg_sq%0d: got %0d want %0d", k + 1, sq_of(k), model_sq[k]);
      end
    end
    serve(0);
    finish_ho(0, 2'd1, 3'b000);
  endtask

  task automatic test_handover();
    send_block(79, 59, 29);
    serve(2);
    finish_ho(2, 2'd0, 3'b000);
  endtask

  task automatic test_hysteresis();
    exp_t e;
    send_block(51, 47, 9);
    serve(1);
    send_block(52, 47, 9);
    e.bs  = 1;
    e.tgt = 2'(model_target(1));
    sb_q.push_back(e);
    tick();
    tick();
    e = sb_q.pop_front();
    total++;
    if (tgt_of(e.bs) !== e.tgt) begin
      bad++;
      $display("FAIL reeval_target: got %0d want %0d", tgt_of(e.bs), e.tgt);
    end
    finish_ho(1, 2'd0, 3'b000);
  endtask

  task automatic test_tie_simultaneous();
    send_block(19, 89, 89);
    bus.bs_request = 3'b101;
    serve(0);
    total++;
    if (bus.DM_BS3_target !== 2'd2) begin
      bad++;
      $display("FAIL tie_bs3_ignored: got %0d want 2", bus.DM_BS3_target);
    end
    finish_ho(0, 2'd1, 3'b100);
    serve(2);
    bus.bs_request = 3'b000;
    tick();
    total++;
    if (bus.dm_busy !== 1'b0) begin
      bad++;
      $display("FAIL stay_drop_idle: busy=%b want 0", bus.dm_busy);
    end
  endtask

  task automatic test_timeout_reset();
    int ho0;
    serve(0);
    ho0 = model_ho;
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (bus.dm_busy !== 1'b1 || bus.DM_BS1_target !== 2'd1 || bus.ho_count !== 8'(ho0)) begin
      bad++;
      $display("FAIL report_held: busy=%b target=%0d ho=%0d want busy=1 target=1 ho=%0d",
               bus.dm_busy, bus.DM_BS1_target, bus.ho_count, ho0);
    end
    tick();
    model_ho++;
    total++;
    if (bus.ho_count !== 8'(model_ho) || bus.DM_BS1_target !== 2'd1) begin
      bad++;
      $display("FAIL timeout_hold: ho=%0d target=%0d want ho=%0d target=1",
               bus.ho_count, bus.DM_BS1_target, model_ho);
    end
    tick();
    tick();
    total++;
    if (bus.dm_busy !== 1'b0 || bus.DM_BS1_target !== 2'd0) begin
      bad++;
      $display("FAIL timeout_idle: busy=%b target=%0d want busy=0 target=0",
               bus.dm_busy, bus.DM_BS1_target);
    end
    bus.bs_request = 3'b000;
    serve(0);
    tick();
    reset = 1'b1;
    tick();
    check_reset_state("midreset");
    reset = 1'b0;
    bus.bs_request = 3'b000;
    for (int k = 0; k < 3; k++) model_sq[k] = 127;
    model_ho = 0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.rssi_valid = 1'b0;
    bus.rssi_bs1   = '0;
    bus.rssi_bs2   = '0;
    bus.rssi_bs3   = '0;
    bus.bs_request = '0;
    test_reset();
    test_averaging();
    test_handover();
    test_hysteresis();
    test_tie_simultaneous();
    test_timeout_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
